// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: debounce FSM state encoding
// and a helper mapping a state to the debounced button level.
package btn_pkg;

    localparam logic [1:0] RELEASED    = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;

    // The accepted level is high in HELD and RELEASE_CHK, which is exactly the state MSB.
    function automatic logic level_of(input logic [1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce FSM, debounce/hold counters and
// registered press/release/repeat strobes.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   RELEASED     | accepted level 0, input stable low
//   PRESS_CHK    | input went high, counting stable cycles before accepting
//   HELD         | accepted level 1, hold counter drives auto-repeat
//   RELEASE_CHK  | input went low, counting stable cycles; hold count frozen
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES  = 20000,
    parameter int REP_DELAY  = 500000,
    parameter int REP_PERIOD = 100000,
    parameter int CNT_W      = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REP_DELAY - REP_PERIOD);

    logic             s1_q;
    logic             s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s2_q) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d  = RELEASE_CHK;
                    db_cnt_d = '0;
                end else if (hold_cnt_q == REP_LAST) begin
                    // Reloading leaves REP_PERIOD cycles until the next compare hit.
                    repeat_d   = 1'b1;
                    hold_cnt_d = REP_RELOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (s2_q) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            state_q    <= RELEASED;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            s1_q       <= btn_raw_i;
            s2_q       <= s1_q;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign level_o   = level_of(state_q);
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Input conditioning ahead of gameControl: per-button debounce with press,
// release and auto-repeat strobes, plus plain 2-flop sync of the switches.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = 5,
    parameter int N_SW       = 6,
    parameter int DB_CYCLES  = 20000,
    parameter int REP_DELAY  = 500000,
    parameter int REP_PERIOD = 100000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic             rnd_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_SW-1:0]  sw_sync,
    output logic             rnd_sync
);

    logic [N_SW-1:0] sw_s1_q;
    logic [N_SW-1:0] sw_s2_q;
    logic            rnd_s1_q;
    logic            rnd_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            rnd_s1_q <= 1'b0;
            rnd_s2_q <= 1'b0;
        end else begin
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
            rnd_s1_q <= rnd_raw;
            rnd_s2_q <= rnd_s1_q;
        end
    end

    assign sw_sync  = sw_s2_q;
    assign rnd_sync = rnd_s2_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_channel #(
            .DB_CYCLES (DB_CYCLES),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk_i    (clk),
            .rst_i    (rst),
            .btn_raw_i(btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .repeat_o (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing inputs,
// all outputs compared every cycle against an event-level reference model.
module tb_btn_conditioner;

    localparam int N_BTN      = 5;
    localparam int N_SW       = 6;
    localparam int DB_CYCLES  = 4;
    localparam int REP_DELAY  = 10;
    localparam int REP_PERIOD = 3;
    localparam int CNT_W      = 5;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic             rnd_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic [N_SW-1:0]  sw_sync;
    logic             rnd_sync;

    btn_conditioner #(
        .N_BTN(N_BTN), .N_SW(N_SW), .DB_CYCLES(DB_CYCLES),
        .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .rnd_raw(rnd_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .sw_sync(sw_sync), .rnd_sync(rnd_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw inputs seen two edges late; a level change is
    // accepted after DB_CYCLES+1 consecutive disagreeing samples; repeats
    // fire at hold tick REP_DELAY, REP_DELAY+REP_PERIOD, ...
    bit               m_d1 [N_BTN];
    bit               m_d2 [N_BTN];
    bit               m_lvl[N_BTN];
    int               m_run[N_BTN];
    int               m_hold[N_BTN];
    logic [N_SW-1:0]  m_sw1, m_sw2;
    bit               m_rnd1, m_rnd2;
    logic [N_BTN-1:0] e_press, e_rel, e_rep, e_lvl;

    task automatic model_edge();
        e_press = '0;
        e_rel   = '0;
        e_rep   = '0;
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_hold[i] = 0;
            end
            m_sw1 = '0; m_sw2 = '0; m_rnd1 = 0; m_rnd2 = 0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                bit seen;
                seen    = m_d2[i];
                m_d2[i] = m_d1[i];
                m_d1[i] = btn_raw[i];
                if (seen != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB_CYCLES + 1) begin
                        m_lvl[i] = seen;
                        m_run[i] = 0;
                        if (seen) begin
                            e_press[i] = 1'b1;
                            m_hold[i]  = 0;
                        end else begin
                            e_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    if (m_lvl[i] && m_run[i] == 0) begin
                        m_hold[i]++;
                        if (m_hold[i] >= REP_DELAY && (m_hold[i] - REP_DELAY) % REP_PERIOD == 0)
                            e_rep[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
            m_sw2  = m_sw1;  m_sw1  = sw_raw;
            m_rnd2 = m_rnd1; m_rnd1 = rnd_raw;
        end
        for (int i = 0; i < N_BTN; i++) e_lvl[i] = m_lvl[i];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("level",   32'(btn_level),   32'(e_lvl));
        check_eq("press",   32'(btn_press),   32'(e_press));
        check_eq("release", 32'(btn_release), 32'(e_rel));
        check_eq("repeat",  32'(btn_repeat),  32'(e_rep));
        check_eq("sw_sync", 32'(sw_sync),     32'(m_sw2));
        check_eq("rnd_sync", 32'(rnd_sync),   32'(m_rnd2));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first, cnt, first_rep;
        rst = 1'b1; btn_raw = '0; sw_raw = '0; rnd_raw = 1'b0;
        run(3);
        check_eq("reset_outs", 32'({btn_level, btn_press, btn_release, btn_repeat, sw_sync, rnd_sync}), 32'd0);
        rst = 1'b0;
        run(3);

        // Clean press on button 0
        btn_raw[0] = 1'b1;
        first = -1; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (btn_press[0]) begin cnt++; if (first < 0) first = i; end
            check_eq("other_quiet", 32'(btn_press[4:1] | btn_level[4:1]), 32'd0);
        end
        check_eq("press_latency", 32'(first), 32'(DB_CYCLES + 3));
        check_eq("press_count", 32'(cnt), 32'd1);
        btn_raw[0] = 1'b0;
        run(12);

        // Glitch filtering on button 2
        cnt = 0;
        btn_raw[2] = 1'b1; run(DB_CYCLES); btn_raw[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (btn_press[2]) cnt++; end
        check_eq("glitch_short", 32'(cnt), 32'd0);
        btn_raw[2] = 1'b1;
        for (int i = 0; i < DB_CYCLES + 1; i++) begin tick(); if (btn_press[2]) cnt++; end
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (btn_press[2]) cnt++; end
        check_eq("glitch_long", 32'(cnt), 32'd1);

        // Auto-repeat on button 1
        btn_raw[1] = 1'b1;
        first = -1; first_rep = -1; cnt = 0;
        for (int i = 1; i <= 37; i++) begin
            tick();
            if (btn_press[1] && first < 0) first = i;
            if (btn_repeat[1]) begin cnt++; if (first_rep < 0) first_rep = i; end
        end
        check_eq("rep_first_ofs", 32'(first_rep - first), 32'(REP_DELAY));
        check_eq("rep_count", 32'(cnt), 32'd7);
        btn_raw[1] = 1'b0;
        run(12);

        // Release bounce on button 3
        btn_raw[3] = 1'b1; run(10);
        cnt = 0;
        btn_raw[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (btn_release[3]) cnt++; end
        btn_raw[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin tick(); if (btn_release[3]) cnt++; end
        check_eq("bounce_no_rel", 32'(cnt), 32'd0);
        check_eq("bounce_level", 32'(btn_level[3]), 32'd1);
        btn_raw[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (btn_release[3]) cnt++; end
        check_eq("release_count", 32'(cnt), 32'd1);
        check_eq("release_level", 32'(btn_level[3]), 32'd0);

        // Reset during PRESS_CHK on button 4
        btn_raw[4] = 1'b1; run(4);
        rst = 1'b1; tick();
        check_eq("rst_mid_outs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
        rst = 1'b0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (btn_press[4] && first < 0) first = i;
        end
        check_eq("rst_repress_lat", 32'(first), 32'(DB_CYCLES + 3));
        btn_raw[4] = 1'b0;
        run(12);

        // Switch synchronisers
        sw_raw = 6'b101010; rnd_raw = 1'b1;
        tick();
        check_eq("sw_after1", 32'(sw_sync), 32'd0);
        tick();
        check_eq("sw_after2", 32'(sw_sync), 32'(6'b101010));
        check_eq("rnd_after2", 32'(rnd_sync), 32'd1);

        // Random bouncing stimulus with occasional resets
        for (int blk = 0; blk < 60; blk++) begin
            int thr;
            case ($urandom_range(0, 3))
                0: thr = 1;
                1: thr = 4;
                2: thr = 12;
                default: thr = 40;
            endcase
            for (int c = 0; c < 50; c++) begin
                for (int b = 0; b < N_BTN; b++)
                    if ($urandom_range(0, thr) == 0) btn_raw[b] = ~btn_raw[b];
                if ($urandom_range(0, 15) == 0) sw_raw = N_SW'($urandom);
                if ($urandom_range(0, 15) == 0) rnd_raw = ~rnd_raw;
                rst = ($urandom_range(0, 400) == 0);
                tick();
            end
        end
        rst = 1'b0;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
